// File: rtl/if_fetch_unit.sv
// Instruction-fetch unit: owns the fetch PC, issues req/gnt/rvalid bus requests, buffers
// returned words in a small FIFO and presents them to decode, obeying hold and jump control.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  hold_flag_i,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_gnt_i,
   input  logic        ibus_rvalid_i,
   input  logic [31:0] ibus_rdata_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [31:0]   pc_reg, pc_next;
   logic [CW-1:0] out_cnt_reg, out_cnt_next;
   logic [CW-1:0] drop_cnt_reg, drop_cnt_next;
   logic [CW-1:0] fifo_cnt_reg, fifo_cnt_next;
   logic [AW-1:0] fifo_wr_ptr_reg, fifo_rd_ptr_reg;
   logic [AW-1:0] aq_wr_ptr_reg, aq_rd_ptr_reg;

   logic [31:0]   aq_mem        [DEPTH];
   logic [31:0]   fifo_addr_mem [DEPTH];
   logic [31:0]   fifo_data_mem [DEPTH];

   logic          inst_valid_reg;
   logic [31:0]   inst_reg;
   logic [31:0]   inst_addr_reg;

   logic [CW:0]   in_use;
   logic          credit_ok;
   logic          issue;
   logic          resp;
   logic          drop;
   logic          push;
   logic          pop;
   logic          out_frozen;

   // Credit covers both in-flight requests and buffered words, so the FIFO can never overflow.
   assign in_use     = {1'b0, out_cnt_reg} + {1'b0, fifo_cnt_reg};
   assign credit_ok  = in_use < (CW+1)'(DEPTH);
   assign ibus_req_o = !rst && !jump_flag_i && (hold_flag_i == 3'd0) && credit_ok;
   assign ibus_addr_o = pc_reg;

   assign issue      = ibus_req_o && ibus_gnt_i;
   // A response with nothing outstanding belongs to a transaction abandoned by reset.
   assign resp       = ibus_rvalid_i && (out_cnt_reg != '0);
   assign drop       = resp && ((drop_cnt_reg != '0) || jump_flag_i);
   assign push       = resp && !drop;
   assign out_frozen = hold_flag_i >= 3'd2;
   assign pop        = !jump_flag_i && !out_frozen && (fifo_cnt_reg != '0);

   always_comb begin
      pc_next       = pc_reg;
      out_cnt_next  = out_cnt_reg;
      drop_cnt_next = drop_cnt_reg;
      fifo_cnt_next = fifo_cnt_reg;

      if (jump_flag_i)
         pc_next = jump_addr_i & 32'hFFFF_FFFC;
      else if (issue)
         pc_next = pc_reg + 32'd4;

      if (issue && !resp)
         out_cnt_next = out_cnt_reg + CW'(1);
      else if (!issue && resp)
         out_cnt_next = out_cnt_reg - CW'(1);

      // Everything still in flight at a redirect is owed a discard, except the word landing now.
      if (jump_flag_i)
         drop_cnt_next = out_cnt_reg - (resp ? CW'(1) : CW'(0));
      else if (resp && (drop_cnt_reg != '0))
         drop_cnt_next = drop_cnt_reg - CW'(1);

      if (jump_flag_i)
         fifo_cnt_next = '0;
      else if (push && !pop)
         fifo_cnt_next = fifo_cnt_reg + CW'(1);
      else if (!push && pop)
         fifo_cnt_next = fifo_cnt_reg - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg          <= RESET_PC & 32'hFFFF_FFFC;
         out_cnt_reg     <= '0;
         drop_cnt_reg    <= '0;
         fifo_cnt_reg    <= '0;
         fifo_wr_ptr_reg <= '0;
         fifo_rd_ptr_reg <= '0;
         aq_wr_ptr_reg   <= '0;
         aq_rd_ptr_reg   <= '0;
      end else begin
         assert (!(push && !pop && (fifo_cnt_reg == CW'(DEPTH))));
         pc_reg       <= pc_next;
         out_cnt_reg  <= out_cnt_next;
         drop_cnt_reg <= drop_cnt_next;
         fifo_cnt_reg <= fifo_cnt_next;
         // The address queue tracks every in-flight request, dropped or not, so it is never flushed.
         if (issue)
            aq_wr_ptr_reg <= aq_wr_ptr_reg + AW'(1);
         if (resp)
            aq_rd_ptr_reg <= aq_rd_ptr_reg + AW'(1);
         if (push)
            fifo_wr_ptr_reg <= fifo_wr_ptr_reg + AW'(1);
         if (jump_flag_i)
            fifo_rd_ptr_reg <= push ? fifo_wr_ptr_reg + AW'(1) : fifo_wr_ptr_reg;
         else if (pop)
            fifo_rd_ptr_reg <= fifo_rd_ptr_reg + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (issue)
         aq_mem[aq_wr_ptr_reg] <= pc_reg;
      if (push) begin
         fifo_addr_mem[fifo_wr_ptr_reg] <= aq_mem[aq_rd_ptr_reg];
         fifo_data_mem[fifo_wr_ptr_reg] <= ibus_rdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inst_valid_reg <= 1'b0;
         inst_reg       <= NOP_INST;
         inst_addr_reg  <= 32'd0;
      end else if (jump_flag_i) begin
         inst_valid_reg <= 1'b0;
         inst_reg       <= NOP_INST;
      end else if (!out_frozen) begin
         if (fifo_cnt_reg != '0) begin
            inst_valid_reg <= 1'b1;
            inst_reg       <= fifo_data_mem[fifo_rd_ptr_reg];
            inst_addr_reg  <= fifo_addr_mem[fifo_rd_ptr_reg];
         end else begin
            inst_valid_reg <= 1'b0;
            inst_reg       <= NOP_INST;
         end
      end
   end

   assign inst_valid_o = inst_valid_reg;
   assign inst_o       = inst_reg;
   assign inst_addr_o  = inst_addr_reg;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: random hold/jump/gnt/latency stimulus against a
// queue-based model of the expected decode stream.
module tb_if_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  hold_flag_i;
   logic        jump_flag_i;
   logic [31:0] jump_addr_i;
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_gnt_i;
   logic        ibus_rvalid_i;
   logic [31:0] ibus_rdata_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;

   if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_INST(NOP_INST)) dut (
      .clk(clk), .rst(rst), .hold_flag_i(hold_flag_i), .jump_flag_i(jump_flag_i),
      .jump_addr_i(jump_addr_i), .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o),
      .ibus_gnt_i(ibus_gnt_i), .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
      .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          ready;
   } pend_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          max_lat = 0;
   logic [31:0] model_pc = RESET_PC;
   logic [31:0] exp_q[$];
   pend_t       mem_q[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h0F0F_1234;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One bus cycle: drive inputs at negedge, then record what the model says the DUT owes.
   task automatic drive_cycle(input logic [2:0] h, input bit j, input logic [31:0] ja,
                              input bit g, input bit r, input bit stray);
      @(negedge clk);
      cyc++;
      rst         = r;
      hold_flag_i = h;
      jump_flag_i = j;
      jump_addr_i = ja;
      ibus_gnt_i  = g;
      if (stray) begin
         ibus_rvalid_i = 1'b1;
         ibus_rdata_i  = $urandom;
      end else if (!r && mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
         ibus_rvalid_i = 1'b1;
         ibus_rdata_i  = mem_word(mem_q[0].addr);
         void'(mem_q.pop_front());
      end else begin
         ibus_rvalid_i = 1'b0;
         ibus_rdata_i  = $urandom;
      end
      #1;
      if (r) begin
         check("req_in_reset", 32'(ibus_req_o), 32'd0);
         exp_q.delete();
         mem_q.delete();
         model_pc = RESET_PC;
      end else begin
         if (h != 3'd0 || j)
            check("req_stalled", 32'(ibus_req_o), 32'd0);
         if (ibus_req_o)
            check("ibus_addr", ibus_addr_o, model_pc);
         if (ibus_req_o && g) begin
            exp_q.push_back(model_pc);
            mem_q.push_back('{model_pc, cyc + 1 + $urandom_range(0, max_lat)});
            $display("req  addr=%h cycle=%0d", model_pc, cyc);
            model_pc = model_pc + 32'd4;
         end
         if (j) begin
            exp_q.delete();
            model_pc = ja & 32'hFFFF_FFFC;
            $display("jump target=%h cycle=%0d", ja, cyc);
         end
      end
   endtask

   // Monitor: after each edge, a valid word with hold<2 in the elapsed cycle is a fresh pop.
   logic        last_valid = 1'b0;
   logic [31:0] last_inst = NOP_INST;
   logic [31:0] last_addr = 32'd0;
   initial begin
      logic [2:0]  h_s;
      logic        j_s, r_s;
      logic [31:0] e;
      forever begin
         @(posedge clk);
         h_s = hold_flag_i;
         j_s = jump_flag_i;
         r_s = rst;
         #2;
         if (r_s) begin
            check("rst_valid", 32'(inst_valid_o), 32'd0);
            check("rst_inst", inst_o, NOP_INST);
            check("rst_addr", inst_addr_o, 32'd0);
         end else if (j_s) begin
            check("jump_valid", 32'(inst_valid_o), 32'd0);
            check("jump_inst", inst_o, NOP_INST);
         end else if (h_s >= 3'd2) begin
            check("frozen_valid", 32'(inst_valid_o), 32'(last_valid));
            check("frozen_inst", inst_o, last_inst);
            check("frozen_addr", inst_addr_o, last_addr);
         end else if (inst_valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_inst: got addr %h, expected no instruction", inst_addr_o);
            end else begin
               e = exp_q.pop_front();
               check("inst_addr", inst_addr_o, e);
               check("inst_data", inst_o, mem_word(e));
               $display("inst addr=%h data=%h", inst_addr_o, inst_o);
            end
         end else begin
            check("idle_inst", inst_o, NOP_INST);
            check("idle_addr", inst_addr_o, last_addr);
         end
         last_valid = inst_valid_o;
         last_inst  = inst_o;
         last_addr  = inst_addr_o;
      end
   end

   initial begin
      int r;
      rst = 1'b1; hold_flag_i = 3'd0; jump_flag_i = 1'b0; jump_addr_i = 32'd0;
      ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = 32'd0;

      // Streaming: gnt tied high, single-cycle memory -> valid from the third edge, no bubbles.
      max_lat = 0;
      repeat (2) drive_cycle(3'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 14; k++) begin
         drive_cycle(3'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
         check("stream_req", 32'(ibus_req_o), 32'd1);
         if (k >= 3) check("stream_valid", 32'(inst_valid_o), 32'd1);
      end

      // Grant withheld: address must hold at the reset PC.
      repeat (2) drive_cycle(3'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         drive_cycle(3'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
         check("gnt_low_addr", ibus_addr_o, RESET_PC);
      end
      repeat (4) drive_cycle(3'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

      // Redirect with two requests in flight.
      max_lat = 3;
      repeat (2) drive_cycle(3'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
      repeat (2) drive_cycle(3'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      drive_cycle(3'd0, 1'b1, 32'h0000_0103, 1'b1, 1'b0, 1'b0);
      drive_cycle(3'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      check("jump_target_addr", ibus_addr_o, 32'h0000_0100);
      repeat (10) drive_cycle(3'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

      // Full hold while the FIFO fills, then release.
      max_lat = 0;
      repeat (4) drive_cycle(3'd3, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      repeat (8) drive_cycle(3'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

      // PC hold keeps draining; jump beats hold=3.
      repeat (3) drive_cycle(3'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      drive_cycle(3'd3, 1'b1, 32'h0000_2000, 1'b1, 1'b0, 1'b0);
      repeat (6) drive_cycle(3'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

      // Reset with a request outstanding, then a stray response.
      max_lat = 3;
      drive_cycle(3'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      drive_cycle(3'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      drive_cycle(3'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      check("restart_addr", ibus_addr_o, RESET_PC);
      repeat (8) drive_cycle(3'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

      // Random traffic.
      for (int k = 0; k < 3000; k++) begin
         logic [2:0] h;
         r = $urandom_range(0, 99);
         h = (r < 70) ? 3'd0 : (r < 80) ? 3'd1 : (r < 90) ? 3'd2 : 3'd3;
         drive_cycle(h, ($urandom_range(0, 99) < 4), $urandom, ($urandom_range(0, 99) < 70),
                     ($urandom_range(0, 999) < 5), 1'b0);
      end

      // Drain: every granted word still owed must reach decode.
      for (int k = 0; k < 300 && (exp_q.size() > 0 || mem_q.size() > 0); k++)
         drive_cycle(3'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      repeat (2) drive_cycle(3'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      check("drain_left", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
